// File: rtl/sid_pkg.sv
// Shared types and constants for the dual-SID core: TDM cycle numbering,
// audio sample type and the I2S slot index used by the audio transmitter.
package sid;

  typedef logic [4:0]         cycle_t;
  typedef logic signed [19:0] s20_t;
  typedef logic [5:0]         i2s_slot_t;

  // TDM cycles at which the filter output stage presents each chip's sample.
  localparam cycle_t AUDIO_L_CYCLE = 5'd9;
  localparam cycle_t AUDIO_R_CYCLE = 5'd14;

  // Word select is high for slots 31..62: it leads the right word's MSB
  // (slot 32) by one SCK and returns low one SCK before the next left MSB.
  function automatic logic i2s_ws_for_slot(input i2s_slot_t k);
    return (k >= 6'd31) && (k <= 6'd62);
  endfunction

endpackage

// File: rtl/sid_i2s_tx_sck_gen.sv
// I2S bit-clock generator: divides clk by 2*SCK_DIV and flags the clk in
// which SCK goes 1->0 so the serializer can update its outputs there.
module sid_i2s_tx_sck_gen #(
  parameter int SCK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic i2s_sck,
  output logic sck_fall
);

  localparam int DW = (SCK_DIV > 2) ? $clog2(SCK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCK_DIV - 1);

  logic [DW-1:0] div;
  logic          div_wrap;

  assign div_wrap = (div == DIV_LAST);
  // The toggle happening this clk is a falling edge when SCK is currently high.
  assign sck_fall = div_wrap & i2s_sck;

  // Half-period counter and SCK toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      div     <= '0;
      i2s_sck <= 1'b0;
    end else if (div_wrap) begin
      div     <= '0;
      i2s_sck <= ~i2s_sck;
    end else begin
      div     <= div + DW'(1);
    end
  end

endmodule

// File: rtl/sid_i2s_tx.sv
// Stereo Philips I2S transmitter for the dual-SID core. Captures the left and
// right filter outputs from their TDM slots as one consistent pair and sends
// the latest pair each 64-SCK frame, re-sending the held pair when none is new.
module sid_i2s_tx
  import sid::*;
#(
  parameter int     SCK_DIV     = 4,
  parameter cycle_t CAP_L_CYCLE = AUDIO_L_CYCLE,
  parameter cycle_t CAP_R_CYCLE = AUDIO_R_CYCLE
) (
  input  logic   clk,
  input  logic   rst,
  input  cycle_t cycle,
  input  s20_t   audio_i,
  output logic   i2s_sck,
  output logic   i2s_ws,
  output logic   i2s_sd,
  output logic   repeat_o
);

  logic        sck_fall;
  logic        cap_l;
  logic        cap_r;
  logic        load;
  s20_t        l_tmp;
  s20_t        pair_l;
  s20_t        pair_r;
  logic        pair_new;
  i2s_slot_t   k;
  i2s_slot_t   k_next;
  logic [63:0] frame;
  logic [63:0] frame_load;

  sid_i2s_tx_sck_gen #(
    .SCK_DIV (SCK_DIV)
  ) u_sck_gen (
    .clk      (clk),
    .rst      (rst),
    .i2s_sck  (i2s_sck),
    .sck_fall (sck_fall)
  );

  assign cap_l      = (cycle == CAP_L_CYCLE);
  assign cap_r      = (cycle == CAP_R_CYCLE);
  assign k_next     = k + 6'd1;
  assign load       = sck_fall && (k_next == 6'd0);
  assign frame_load = {pair_l, 12'b0, pair_r, 12'b0};

  // Capture buffer: left is parked in l_tmp until right arrives, then both
  // move into the pair together so a frame never mixes two SID cycles.
  // A right capture coinciding with a frame load leaves pair_new set.
  always_ff @(posedge clk) begin
    if (rst) begin
      l_tmp    <= '0;
      pair_l   <= '0;
      pair_r   <= '0;
      pair_new <= 1'b0;
    end else begin
      if (cap_l) begin
        l_tmp <= audio_i;
      end
      if (cap_r) begin
        pair_l   <= l_tmp;
        pair_r   <= audio_i;
        pair_new <= 1'b1;
      end else if (load) begin
        pair_new <= 1'b0;
      end
    end
  end

  // Slot counter and serializer; outputs move only on SCK falling edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      k        <= 6'd63;
      frame    <= '0;
      i2s_sd   <= 1'b0;
      i2s_ws   <= 1'b0;
      repeat_o <= 1'b0;
    end else begin
      repeat_o <= 1'b0;
      if (sck_fall) begin
        k      <= k_next;
        i2s_ws <= i2s_ws_for_slot(k_next);
        if (load) begin
          frame    <= frame_load;
          i2s_sd   <= pair_l[19];
          repeat_o <= ~pair_new;
        end else begin
          i2s_sd <= frame[6'd63 - k_next];
        end
      end
    end
  end

endmodule

// File: tb/tb_sid_i2s_tx.sv
// Bench for sid_i2s_tx: directed and random capture traffic, a frame-level
// reference model feeding an expected queue, and a monitor on the I2S pins.
module tb_sid_i2s_tx;
  import sid::*;

  localparam int D          = 2;
  localparam int W          = 41;
  localparam int FRAME_CLKS = 128 * D;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  cycle_t cycle = '0;
  s20_t   audio_i = '0;
  logic   i2s_sck;
  logic   i2s_ws;
  logic   i2s_sd;
  logic   repeat_o;

  always #5 clk = ~clk;

  sid_i2s_tx #(
    .SCK_DIV     (D),
    .CAP_L_CYCLE (AUDIO_L_CYCLE),
    .CAP_R_CYCLE (AUDIO_R_CYCLE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cycle    (cycle),
    .audio_i  (audio_i),
    .i2s_sck  (i2s_sck),
    .i2s_ws   (i2s_ws),
    .i2s_sd   (i2s_sd),
    .repeat_o (repeat_o)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];  // {repeat, left, right} per frame

  task automatic chk(input string nm, input logic [63:0] got_v, input logic [63:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, got_v, exp_v);
    end
  endtask

  // True when clk edge number x (counted from reset release) is the SCK
  // falling edge that starts a frame: falls every 2*D edges, slot 0 every 64th.
  function automatic logic is_load(input int x);
    return (x > 0) && (x % (2 * D) == 0) && (((x / (2 * D)) - 1) % 64 == 0);
  endfunction

  function automatic int slot_at(input int x);
    return ((x / (2 * D)) - 1) % 64;
  endfunction

  // ---------------- reference model ----------------
  int          n = 0;          // clk edges since reset release
  logic        m_rst_clk = 1'b0;
  logic [19:0] m_ltmp = '0;
  logic [19:0] m_pl = '0;
  logic [19:0] m_pr = '0;
  logic        m_new = 1'b0;

  // Frame boundaries are computed from the edge count; a frame snapshots the
  // pair held before this edge's capture, so a coincident right capture is
  // deferred to the next frame.
  always @(posedge clk) begin
    m_rst_clk = 1'b0;
    if (rst) begin
      n         = 0;
      m_ltmp    = '0;
      m_pl      = '0;
      m_pr      = '0;
      m_new     = 1'b0;
      m_rst_clk = 1'b1;
      exp_q.delete();
    end else begin
      n++;
      if (is_load(n)) begin
        exp_q.push_back({~m_new, m_pl, m_pr});
        m_new = 1'b0;
      end
      if (cycle == AUDIO_L_CYCLE) begin
        m_ltmp = audio_i;
      end else if (cycle == AUDIO_R_CYCLE) begin
        m_pl  = m_ltmp;
        m_pr  = audio_i;
        m_new = 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic        prev_sck = 1'b0;
  int          mslot = 63;
  logic        have_exp = 1'b0;
  logic [W-1:0] cur_exp = '0;
  logic [63:0] got_frame = '0;
  int          frames_checked = 0;

  // Sample pins on the falling clk edge, track slots from observed SCK falls.
  always @(negedge clk) begin
    chk("sck_level", 64'(i2s_sck), 64'((n / D) % 2));
    if (m_rst_clk) begin
      chk("rst_ws", 64'(i2s_ws), 64'd0);
      chk("rst_sd", 64'(i2s_sd), 64'd0);
      chk("rst_repeat", 64'(repeat_o), 64'd0);
      mslot    = 63;
      have_exp = 1'b0;
      prev_sck = 1'b0;
    end else begin
      if (prev_sck && !i2s_sck) begin
        mslot = (mslot + 1) % 64;
        chk("ws", 64'(i2s_ws), 64'((mslot >= 31) && (mslot <= 62)));
        if (mslot == 0) begin
          got_frame = '0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            have_exp = 1'b0;
            $display("FAIL frame_start at %0t: got=frame start expected=no frame pending", $time);
          end else begin
            cur_exp  = exp_q.pop_front();
            have_exp = 1'b1;
            chk("repeat", 64'(repeat_o), 64'(cur_exp[40]));
          end
        end
        got_frame[63 - mslot] = i2s_sd;
        if (mslot == 63 && have_exp) begin
          chk("frame", got_frame, {cur_exp[39:20], 12'b0, cur_exp[19:0], 12'b0});
          frames_checked++;
        end
      end else begin
        chk("repeat_idle", 64'(repeat_o), 64'd0);
      end
      prev_sck = i2s_sck;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic cycle_t rand_idle_cycle();
    cycle_t c;
    c = cycle_t'($urandom_range(0, 31));
    while (c == AUDIO_L_CYCLE || c == AUDIO_R_CYCLE) c = cycle_t'($urandom_range(0, 31));
    return c;
  endfunction

  task automatic set_idle();
    cycle   = rand_idle_cycle();
    audio_i = s20_t'($urandom);
  endtask

  task automatic step(input cycle_t c, input s20_t v);
    @(negedge clk);
    cycle   = c;
    audio_i = v;
  endtask

  task automatic idle(input int cnt);
    repeat (cnt) begin
      @(negedge clk);
      set_idle();
    end
  endtask

  // Stops at the negedge just before a frame-load edge, inputs not yet set.
  task automatic wait_pre_load();
    for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
      @(negedge clk);
      if (is_load(n + 1)) return;
      set_idle();
    end
    checks++;
    errors++;
    $display("FAIL wait_pre_load at %0t: got=no frame boundary expected=boundary within %0d clks", $time, 2 * FRAME_CLKS);
  endtask

  // Stops at the negedge right after the fall that emitted slot s.
  task automatic wait_slot(input int s);
    for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
      @(negedge clk);
      if (n > 0 && n % (2 * D) == 0 && slot_at(n) == s) return;
      set_idle();
    end
    checks++;
    errors++;
    $display("FAIL wait_slot at %0t: got=slot %0d not reached expected=within %0d clks", $time, s, 2 * FRAME_CLKS);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    set_idle();

    // Frame 0 goes out empty with repeat; capture the directed pair during it.
    wait_pre_load();
    set_idle();
    step(AUDIO_L_CYCLE, s20_t'(20'h80001));
    step(5'd3, s20_t'($urandom));
    step(AUDIO_R_CYCLE, s20_t'(20'h7FFFE));
    idle(2);

    // Frame 1 carries the directed pair; only a new left arrives during it.
    wait_pre_load();
    set_idle();
    idle(10);
    step(AUDIO_L_CYCLE, s20_t'(20'h12345));
    idle(2);

    // Frame 2 re-sends the held pair; then a right capture lands on the load.
    wait_pre_load();
    set_idle();
    idle(20);
    step(AUDIO_L_CYCLE, s20_t'($urandom));
    wait_pre_load();
    cycle   = AUDIO_R_CYCLE;
    audio_i = s20_t'($urandom);

    // Frame 4 loads the pair that collided with frame 3's load.
    wait_pre_load();
    set_idle();

    // Random traffic across several frames.
    repeat (6 * FRAME_CLKS) begin
      int r;
      @(negedge clk);
      r = $urandom_range(0, 199);
      if (r == 0)      cycle = AUDIO_L_CYCLE;
      else if (r == 1) cycle = AUDIO_R_CYCLE;
      else             cycle = rand_idle_cycle();
      audio_i = s20_t'($urandom);
    end

    // Reset for one clk right after slot 40 goes out.
    step(AUDIO_L_CYCLE, s20_t'($urandom));
    step(AUDIO_R_CYCLE, s20_t'($urandom));
    wait_slot(40);
    rst = 1'b1;
    set_idle();
    @(negedge clk);
    rst = 1'b0;

    // First frame after reset must be empty; then one more fresh pair.
    wait_pre_load();
    set_idle();
    idle(30);
    step(AUDIO_L_CYCLE, s20_t'($urandom));
    step(AUDIO_R_CYCLE, s20_t'($urandom));
    wait_pre_load();
    set_idle();
    idle(FRAME_CLKS + 4 * D);

    chk("frames_checked", 64'(frames_checked >= 10), 64'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog in case stimulus never completes.
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog at %0t: got=still running expected=finished", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
